// File: rtl/na_sequencer.sv
// ---------------------------------------------------------------------------
// na_sequencer
//
// Valve and pump sequencer for a nucleic-acid extraction cartridge. One run
// walks LOAD_BEAD -> LOAD_CELL -> LYSIS -> MIX -> WASH -> ELUTE -> COLLECT ->
// DONE. Each fluidic step is preceded by a single all-closed GAP cycle, so
// the valves always break before they make.
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          run request, honoured only in IDLE when abort is low
//   abort          stop request, returns to IDLE on the next edge
//   *_ctl          valve controls, 1 = open
//   pump1..pump3   peristaltic pump valves, 1 = open
//   busy           high in every state except IDLE
//   done           high for the single DONE cycle
//   aborted        high for the IDLE cycle that follows an abort
//   state          current state encoding
// ---------------------------------------------------------------------------
module na_sequencer #(
  parameter int LOAD_CYCLES    = 8,
  parameter int LYSIS_CYCLES   = 8,
  parameter int PUMP_DIV       = 4,
  parameter int MIX_ROUNDS     = 2,
  parameter int WASH_CYCLES    = 8,
  parameter int ELUTE_CYCLES   = 8,
  parameter int COLLECT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       lysis_ctl,
  output logic       wash_ctl,
  output logic       elute_ctl,
  output logic       horiz_ctl,
  output logic       vertical_ctl,
  output logic       dead_end_ctl,
  output logic       loop_exit_ctl,
  output logic       bead_vtl_ctl,
  output logic       bead_trap_ctl,
  output logic       collection_ctl,
  output logic       pump1,
  output logic       pump2,
  output logic       pump3,
  output logic       busy,
  output logic       done,
  output logic       aborted,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_GAP       = 4'd1,
    S_LOAD_BEAD = 4'd2,
    S_LOAD_CELL = 4'd3,
    S_LYSIS     = 4'd4,
    S_MIX       = 4'd5,
    S_WASH      = 4'd6,
    S_ELUTE     = 4'd7,
    S_COLLECT   = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  // Last counter value of each timed state (counter starts at 0 on entry).
  localparam logic [15:0] LOAD_LAST    = 16'(LOAD_CYCLES - 1);
  localparam logic [15:0] LYSIS_LAST   = 16'(LYSIS_CYCLES - 1);
  localparam logic [15:0] MIX_LAST     = 16'(MIX_ROUNDS * 6 * PUMP_DIV - 1);
  localparam logic [15:0] WASH_LAST    = 16'(WASH_CYCLES - 1);
  localparam logic [15:0] ELUTE_LAST   = 16'(ELUTE_CYCLES - 1);
  localparam logic [15:0] COLLECT_LAST = 16'(COLLECT_CYCLES - 1);
  localparam logic [15:0] DIV_LAST     = 16'(PUMP_DIV - 1);

  state_t      cur_state;
  state_t      nxt_state;
  state_t      gap_target;
  state_t      gap_target_nxt;
  logic [15:0] dur_cnt;
  logic [15:0] div_cnt;
  logic [2:0]  phase;
  logic        aborted_q;

  // State register, duration counter, pump rotation and abort flag. The GAP
  // state remembers which step it leads into, so one GAP encoding serves
  // every transition. The counter is cleared whenever the state changes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state  <= S_IDLE;
      gap_target <= S_IDLE;
      dur_cnt    <= 16'd0;
      div_cnt    <= 16'd0;
      phase      <= 3'd0;
      aborted_q  <= 1'b0;
    end else begin
      cur_state  <= nxt_state;
      gap_target <= gap_target_nxt;
      aborted_q  <= abort && (cur_state != S_IDLE);

      if ((nxt_state != cur_state) || (cur_state == S_IDLE))
        dur_cnt <= 16'd0;
      else
        dur_cnt <= dur_cnt + 16'd1;

      // Pump phase only advances while staying in MIX, so the first MIX
      // cycle always presents phase 0.
      if ((cur_state == S_MIX) && (nxt_state == S_MIX)) begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= 16'd0;
          phase   <= (phase == 3'd5) ? 3'd0 : phase + 3'd1;
        end else begin
          div_cnt <= div_cnt + 16'd1;
        end
      end else begin
        div_cnt <= 16'd0;
        phase   <= 3'd0;
      end
    end
  end

  // Next-state logic. Abort overrides everything outside IDLE; unused
  // encodings fall back to IDLE.
  always_comb begin
    nxt_state      = cur_state;
    gap_target_nxt = gap_target;
    case (cur_state)
      S_IDLE: begin
        if (start && !abort) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_LOAD_BEAD;
        end
      end
      S_GAP: nxt_state = gap_target;
      S_LOAD_BEAD: begin
        if (dur_cnt == LOAD_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_LOAD_CELL;
        end
      end
      S_LOAD_CELL: begin
        if (dur_cnt == LOAD_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_LYSIS;
        end
      end
      S_LYSIS: begin
        if (dur_cnt == LYSIS_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_MIX;
        end
      end
      S_MIX: begin
        if (dur_cnt == MIX_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_WASH;
        end
      end
      S_WASH: begin
        if (dur_cnt == WASH_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_ELUTE;
        end
      end
      S_ELUTE: begin
        if (dur_cnt == ELUTE_LAST) begin
          nxt_state      = S_GAP;
          gap_target_nxt = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (dur_cnt == COLLECT_LAST)
          nxt_state = S_DONE;
      end
      S_DONE:  nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase

    if (abort && (cur_state != S_IDLE))
      nxt_state = S_IDLE;
  end

  // Output decode: valves and pumps are a pure function of the state, so
  // GAP, IDLE and DONE are all-closed by the defaults.
  always_comb begin
    lysis_ctl      = 1'b0;
    wash_ctl       = 1'b0;
    elute_ctl      = 1'b0;
    horiz_ctl      = 1'b0;
    vertical_ctl   = 1'b0;
    dead_end_ctl   = 1'b0;
    loop_exit_ctl  = 1'b0;
    bead_vtl_ctl   = 1'b0;
    bead_trap_ctl  = 1'b0;
    collection_ctl = 1'b0;
    pump1          = 1'b0;
    pump2          = 1'b0;
    pump3          = 1'b0;
    case (cur_state)
      S_LOAD_BEAD: begin
        bead_vtl_ctl  = 1'b1;
        bead_trap_ctl = 1'b1;
        vertical_ctl  = 1'b1;
      end
      S_LOAD_CELL: begin
        horiz_ctl    = 1'b1;
        vertical_ctl = 1'b1;
      end
      S_LYSIS: begin
        lysis_ctl    = 1'b1;
        vertical_ctl = 1'b1;
      end
      S_MIX: begin
        vertical_ctl = 1'b1;
        dead_end_ctl = 1'b1;
        case (phase)
          3'd0:    {pump1, pump2, pump3} = 3'b011;
          3'd1:    {pump1, pump2, pump3} = 3'b001;
          3'd2:    {pump1, pump2, pump3} = 3'b101;
          3'd3:    {pump1, pump2, pump3} = 3'b100;
          3'd4:    {pump1, pump2, pump3} = 3'b110;
          3'd5:    {pump1, pump2, pump3} = 3'b010;
          default: {pump1, pump2, pump3} = 3'b000;
        endcase
      end
      S_WASH: begin
        wash_ctl      = 1'b1;
        vertical_ctl  = 1'b1;
        bead_trap_ctl = 1'b1;
      end
      S_ELUTE: begin
        elute_ctl     = 1'b1;
        vertical_ctl  = 1'b1;
        bead_trap_ctl = 1'b1;
        loop_exit_ctl = 1'b1;
      end
      S_COLLECT: begin
        collection_ctl = 1'b1;
        bead_trap_ctl  = 1'b1;
        loop_exit_ctl  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy    = (cur_state != S_IDLE);
  assign done    = (cur_state == S_DONE);
  assign aborted = aborted_q;
  assign state   = cur_state;

endmodule

// File: tb/tb_na_sequencer.sv
// ---------------------------------------------------------------------------
// tb_na_sequencer
//
// Directed bench for na_sequencer at default parameters. Cycle k is the
// clock period that follows edge k-1, where edge 0 is the edge that samples
// the start pulse. Outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_na_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl;
  logic       dead_end_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl;
  logic       collection_ctl;
  logic       pump1, pump2, pump3;
  logic       busy, done, aborted;
  logic [3:0] state;

  logic [9:0] valves;
  logic [2:0] pumps;

  int checks;
  int failures;
  int cyc;

  logic [2:0] pumpPattern [6];

  na_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .lysis_ctl      (lysis_ctl),
    .wash_ctl       (wash_ctl),
    .elute_ctl      (elute_ctl),
    .horiz_ctl      (horiz_ctl),
    .vertical_ctl   (vertical_ctl),
    .dead_end_ctl   (dead_end_ctl),
    .loop_exit_ctl  (loop_exit_ctl),
    .bead_vtl_ctl   (bead_vtl_ctl),
    .bead_trap_ctl  (bead_trap_ctl),
    .collection_ctl (collection_ctl),
    .pump1          (pump1),
    .pump2          (pump2),
    .pump3          (pump3),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted),
    .state          (state)
  );

  assign valves = {lysis_ctl, wash_ctl, elute_ctl, horiz_ctl, vertical_ctl,
                   dead_end_ctl, loop_exit_ctl, bead_vtl_ctl, bead_trap_ctl,
                   collection_ctl};
  assign pumps  = {pump1, pump2, pump3};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc,
             observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a);
    start = s;
    abort = a;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic gotoCycle(input int n);
    while (cyc < n) nextCycle();
  endtask

  // Nominal state timeline with default parameters.
  function automatic logic [3:0] expState(input int k);
    if (k == 1)              return 4'd1;
    else if (k <= 9)         return 4'd2;
    else if (k == 10)        return 4'd1;
    else if (k <= 18)        return 4'd3;
    else if (k == 19)        return 4'd1;
    else if (k <= 27)        return 4'd4;
    else if (k == 28)        return 4'd1;
    else if (k <= 76)        return 4'd5;
    else if (k == 77)        return 4'd1;
    else if (k <= 85)        return 4'd6;
    else if (k == 86)        return 4'd1;
    else if (k <= 94)        return 4'd7;
    else if (k == 95)        return 4'd1;
    else if (k <= 99)        return 4'd8;
    else if (k == 100)       return 4'd9;
    else                     return 4'd0;
  endfunction

  // Valve vector order: lysis wash elute horiz vertical dead_end loop_exit
  // bead_vtl bead_trap collection.
  function automatic logic [9:0] expValves(input logic [3:0] s);
    case (s)
      4'd2:    return 10'b0000100110;
      4'd3:    return 10'b0001100000;
      4'd4:    return 10'b1000100000;
      4'd5:    return 10'b0000110000;
      4'd6:    return 10'b0100100010;
      4'd7:    return 10'b0010101010;
      4'd8:    return 10'b0000001011;
      default: return 10'b0000000000;
    endcase
  endfunction

  // Starts a run from IDLE and checks every cycle through the return to
  // IDLE. A nonzero pulseAt raises start for that one mid-run cycle.
  task automatic runTimeline(input int pulseAt);
    logic [3:0] es;
    logic [2:0] ep;
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    cyc = 1;
    applyStimulus(1'b0, 1'b0);
    for (int k = 1; k <= 101; k++) begin
      if (k > 1) nextCycle();
      es = expState(k);
      ep = (es == 4'd5) ? pumpPattern[((k - 29) / 4) % 6] : 3'b000;
      checkOutput("run_state", 16'(state), 16'(es));
      checkOutput("run_valves", 16'(valves), 16'(expValves(es)));
      checkOutput("run_pumps", 16'(pumps), 16'(ep));
      checkOutput("run_done", 16'(done), 16'(k == 100));
      checkOutput("run_busy", 16'(busy), 16'(es != 4'd0));
      checkOutput("run_aborted", 16'(aborted), 16'd0);
      applyStimulus(k == pulseAt, 1'b0);
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  // Invariant and break-before-make monitor, active every cycle.
  always @(negedge clk) begin
    checkOutput("inv_one_reagent",
                16'(32'(lysis_ctl) + 32'(wash_ctl) + 32'(elute_ctl) <= 1), 16'd1);
    checkOutput("inv_collect_wash", 16'(collection_ctl && wash_ctl), 16'd0);
    checkOutput("inv_pumps_not_all", 16'(pumps == 3'b111), 16'd0);
    if (state == 4'd1)
      checkOutput("gap_all_closed", 16'({valves, pumps}), 16'd0);
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    pumpPattern[0] = 3'b011;
    pumpPattern[1] = 3'b001;
    pumpPattern[2] = 3'b101;
    pumpPattern[3] = 3'b100;
    pumpPattern[4] = 3'b110;
    pumpPattern[5] = 3'b010;

    // Reset state.
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0);
    nextCycle();
    nextCycle();
    checkOutput("reset_state", 16'(state), 16'd0);
    checkOutput("reset_outputs", 16'({valves, pumps}), 16'd0);
    checkOutput("reset_flags", 16'({busy, done, aborted}), 16'd0);
    rst_n = 1'b1;
    nextCycle();
    checkOutput("idle_wait", 16'(state), 16'd0);

    // start together with abort in IDLE is ignored.
    $display("[TB] start+abort in IDLE");
    applyStimulus(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput("idle_abort_state", 16'(state), 16'd0);
      checkOutput("idle_abort_busy", 16'(busy), 16'd0);
      checkOutput("idle_abort_flag", 16'(aborted), 16'd0);
    end
    applyStimulus(1'b0, 1'b0);
    nextCycle();

    // Nominal run.
    $display("[TB] nominal run");
    runTimeline(0);
    nextCycle();

    // Abort during MIX.
    $display("[TB] abort at cycle 40");
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    cyc = 1;
    applyStimulus(1'b0, 1'b0);
    gotoCycle(40);
    checkOutput("pre_abort_state", 16'(state), 16'd5);
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 1'b0);
    checkOutput("abort_state", 16'(state), 16'd0);
    checkOutput("abort_outputs", 16'({valves, pumps}), 16'd0);
    checkOutput("abort_done", 16'(done), 16'd0);
    checkOutput("abort_flag", 16'(aborted), 16'd1);
    while (cyc < 60) begin
      nextCycle();
      checkOutput("post_abort_flag", 16'(aborted), 16'd0);
      checkOutput("post_abort_done", 16'(done), 16'd0);
      checkOutput("post_abort_state", 16'(state), 16'd0);
    end

    // Mid-run start pulse has no effect.
    $display("[TB] start pulse at cycle 50");
    runTimeline(50);
    nextCycle();

    // Reset during ELUTE.
    $display("[TB] reset at cycle 90");
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    cyc = 1;
    applyStimulus(1'b0, 1'b0);
    gotoCycle(90);
    checkOutput("pre_reset_state", 16'(state), 16'd7);
    rst_n = 1'b0;
    nextCycle();
    rst_n = 1'b1;
    checkOutput("midreset_state", 16'(state), 16'd0);
    checkOutput("midreset_outputs", 16'({valves, pumps}), 16'd0);
    checkOutput("midreset_flags", 16'({busy, done, aborted}), 16'd0);
    nextCycle();
    checkOutput("midreset_wait", 16'(state), 16'd0);
    runTimeline(0);
    nextCycle();

    // start held high gives back-to-back runs.
    $display("[TB] back-to-back runs");
    applyStimulus(1'b1, 1'b0);
    nextCycle();
    cyc = 1;
    gotoCycle(100);
    checkOutput("b2b_done", 16'(done), 16'd1);
    nextCycle();
    checkOutput("b2b_idle", 16'(state), 16'd0);
    nextCycle();
    checkOutput("b2b_restart", 16'(state), 16'd1);
    applyStimulus(1'b0, 1'b1);
    nextCycle();
    checkOutput("b2b_abort", 16'(state), 16'd0);
    applyStimulus(1'b0, 1'b0);
    nextCycle();

    // Random start/abort traffic; the monitor checks invariants throughout.
    $display("[TB] random start/abort");
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0);
    nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
